keypad_scan_ctrl: RTL
=====================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (all state updates on rising edge) and rst (sampled only at clk rising edge).
REQ-002 Parameters SHALL be: ROWS, default 4, number of driven rows, 2..16.
REQ-003 COLS, default 4, number of sensed columns, 2..16.
REQ-004 SCAN_DIV, default 6250000, clk cycles per scan tick, at least 2.
REQ-005 DEBOUNCE, default 30, consecutive stable clk cycles required to accept a press or a release, at least 2.
REQ-006 FIFO_DEPTH, default 4, event FIFO entries, a power of 2 and at least 2.
REQ-007 REL_EVENTS, default 0; when 1, releases also generate FIFO events.
REQ-008 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- col_in  in  COLS  column sense, active low
- row_out  out  ROWS  row drive, exactly one bit low
- key_code  out  CW+1  FIFO head; MSB=1 means release, low CW bits = row*COLS+col, where CW=clog2(ROWS*COLS)
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head
- pressed  out  1  debounced key-held level
- overflow  out  1  sticky, an event was dropped

Function
REQ-009 The divider SHALL count 0..SCAN_DIV-1 and run freely in every state; a tick is the cycle where the count equals SCAN_DIV-1.
REQ-010 The FSM SHALL have four states: SCAN, PRESS_DB, HELD, REL_DB.
REQ-011 In SCAN, on a tick:
- exactly one col_in bit low: capture active row index and column index, clear the debounce counter, go to PRESS_DB; row_out is frozen.
- no col_in bit low: advance the active row index by 1, wrapping ROWS-1 to 0.
- two or more col_in bits low (ghosting): treat as no key and advance the row.
REQ-012 In PRESS_DB, each cycle:
- col_in equals the captured pattern: increment the counter.
- col_in differs: return to SCAN with no event.
- counter reaches DEBOUNCE-1 with a match: push a press event (MSB=0), set pressed=1, go to HELD.
REQ-013 In HELD, the first cycle with all col_in bits high SHALL clear the counter and enter REL_DB.
REQ-014 In REL_DB, each cycle:
- all bits high: increment the counter.
- any bit low: return to HELD, with pressed still 1.
- counter reaches DEBOUNCE-1: pressed=0, go to SCAN, push a release event (MSB=1, same code) if REL_EVENTS=1.
REQ-015 row_out SHALL change only on a SCAN tick and SHALL stay frozen in PRESS_DB, HELD and REL_DB.
REQ-016 The FIFO SHALL be show-ahead: key_code is the head while key_valid=1; a pop occurs on a cycle with key_valid and key_ready both 1.
REQ-017 Event latency: key_valid SHALL rise the cycle after the push into an empty FIFO.
REQ-018 Push into a full FIFO without a pop in the same cycle SHALL drop the event and set overflow=1.
REQ-019 Push and pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-020 Pop when empty SHALL be ignored.
REQ-021 key_code SHALL be all ones while key_valid=0.

Reset
REQ-022 On rst the block SHALL set:
- state SCAN
- active row 0, so row_out = all ones with bit 0 low
- divider and debounce counters 0
- FIFO empty
- key_valid=0, pressed=0, overflow=0, key_code all ones
REQ-023 rst asserted mid-debounce or mid-hold SHALL discard the pending event.
REQ-024 overflow SHALL clear only on rst.

Structure
REQ-025 Package keypad_pkg SHALL hold the FSM state enum and the CW width helper function.
REQ-026 The FIFO SHALL be a sub-module, keypad_event_fifo, parametrised by width and depth, with push/pop/full/empty/overflow ports.

Verification
Bench parameters: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=8, FIFO_DEPTH=4, unless a case states otherwise.
REQ-027 Reset then idle (col_in=4'hF): row_out SHALL cycle 1110, 1101, 1011, 0111, 1110 with one step every 4 clk, and key_valid SHALL stay 0.
REQ-028 Row 2 active with col_in=4'b1101 held stable: exactly one press event, key_code=0_1001 (9), with pressed rising 8 clk after the capture tick.
REQ-029 Same as REQ-028 with a col_in glitch to 4'hF on the 5th debounce cycle: no event, and scanning resumes on the next tick.
REQ-030 col_in=4'b1100 (two columns low): no event, and the row continues to rotate.
REQ-031 key_ready=0 with 5 distinct presses: 4 events held in order, overflow=1; then the same-cycle push+pop-when-full case SHALL keep overflow unchanged and the count at 4.
REQ-032 REL_EVENTS=1, press then release of key 9: events 0_1001 then 1_1001, and a 3-cycle bounce during REL_DB keeps pressed=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller.
package keypad_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } kp_state_e;

  // Width of the key index row*COLS+col.
  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Show-ahead event FIFO: the head is visible while non-empty, pops are ignored
// when empty, and a push into a full FIFO survives only if a pop frees a slot.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers, occupancy and the sticky drop flag.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CNTW'(DEPTH));
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push && full && !do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNTW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNTW'(1);
    end
    head     = empty ? '1 : mem_q[rd_ptr_q];
    overflow = overflow_q;
  end

  // Control registers; reset empties the FIFO and clears the drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; empty entries are never presented.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller with press/release debounce and event FIFO.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SCAN     | rotate the low row on each scan tick, look for one low column
// ST_PRESS_DB | row frozen, count cycles the captured column pattern holds
// ST_HELD     | key accepted, pressed=1, wait for all columns to go high
// ST_REL_DB   | count all-high cycles; any low column returns to ST_HELD
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 6250000,
  parameter int DEBOUNCE   = 30,
  parameter int FIFO_DEPTH = 4,
  parameter int REL_EVENTS = 0,
  localparam int CW        = code_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [CW:0]     key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            pressed,
  output logic            overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE);
  localparam int RW    = $clog2(ROWS);
  localparam int CIW   = $clog2(COLS);

  kp_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [COLS-1:0]  pat_q, pat_d;
  logic [CW-1:0]    code_q, code_d;
  logic             pressed_q, pressed_d;

  logic             tick, db_done, all_high, one_low;
  logic [CIW-1:0]   col_idx;
  logic [CW-1:0]    cap_code;
  logic             push;
  logic [CW:0]      push_data;
  logic             fifo_empty;

  // Column decode: a single low column names the key on the active row.
  always_comb begin
    all_high = &col_in;
    one_low  = $onehot(~col_in);
    col_idx  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_in[c]) col_idx = CIW'(c);
    end
    cap_code = CW'(int'(row_q) * COLS + int'(col_idx));
  end

  // Scan divider, debounce counting and state transitions.
  always_comb begin
    tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    db_done   = (cnt_q == DB_W'(DEBOUNCE - 1));
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    code_d    = code_q;
    pressed_d = pressed_q;
    push      = 1'b0;
    push_data = {1'b0, code_q};
    unique case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (one_low) begin
            pat_d   = col_in;
            code_d  = cap_code;
            cnt_d   = '0;
            state_d = ST_PRESS_DB;
          end else begin
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
          end
        end
      end
      ST_PRESS_DB: begin
        if (col_in != pat_q) begin
          state_d = ST_SCAN;
        end else if (db_done) begin
          push      = 1'b1;
          pressed_d = 1'b1;
          state_d   = ST_HELD;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (all_high) begin
          cnt_d   = '0;
          state_d = ST_REL_DB;
        end
      end
      ST_REL_DB: begin
        if (!all_high) begin
          state_d = ST_HELD;
        end else if (db_done) begin
          pressed_d = 1'b0;
          state_d   = ST_SCAN;
          push      = (REL_EVENTS != 0);
          push_data = {1'b1, code_q};
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // State registers; reset drops any half-debounced key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      div_q     <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      pat_q     <= '1;
      code_q    <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
    end
  end

  keypad_event_fifo #(
    .WIDTH (CW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (key_ready),
    .head      (key_code),
    .full      (),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign row_out   = ~(ROWS'(1) << row_q);
  assign key_valid = !fifo_empty;
  assign pressed   = pressed_q;

endmodule
